// File: rtl/e_mul_div_unit_pkg.sv
// Shared MDU definitions: op encodings, default latencies, state type.
// Also the is_md_op() helper used by the E and AT controllers.
`timescale 1ns/1ps
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5,
        MDU_MFHI  = 3'd6,
        MDU_MFLO  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_e;

    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;

    function automatic logic is_md_op(mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/e_mul_div_unit_if.sv
// E-stage <-> MDU bundle: issue side from the pipeline,
// busy flag and HI/LO read values back from the unit.
`timescale 1ns/1ps
interface e_mul_div_unit_if;
    import mdu_pkg::*;

    logic        E_start;
    mdu_op_e     E_mdu_op;
    logic [31:0] E_data1;
    logic [31:0] E_data2;
    logic        E_busy;
    logic [31:0] E_hi;
    logic [31:0] E_lo;
    logic [31:0] E_mdu_out;

    modport master (
        output E_start, E_mdu_op, E_data1, E_data2,
        input  E_busy, E_hi, E_lo, E_mdu_out
    );

    modport slave (
        input  E_start, E_mdu_op, E_data1, E_data2,
        output E_busy, E_hi, E_lo, E_mdu_out
    );

endinterface

// File: rtl/e_mul_div_unit_div.sv
// Combinational signed/unsigned divide: quotient truncates to zero,
// remainder follows the dividend sign; flags a zero divisor.
`timescale 1ns/1ps
module mdu_div_core (
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        is_signed,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        div_zero
);

    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] uq;
    logic [31:0] ur;

    // 0x80000000 / -1 falls out naturally: |a| = 2^31 fits unsigned
    always_comb begin
        neg_a    = is_signed & dividend[31];
        neg_b    = is_signed & divisor[31];
        mag_a    = neg_a ? -dividend : dividend;
        mag_b    = neg_b ? -divisor : divisor;
        div_zero = (divisor == 32'd0);
        uq       = div_zero ? 32'd0 : mag_a / mag_b;
        ur       = div_zero ? 32'd0 : mag_a % mag_b;
        quot     = (neg_a ^ neg_b) ? -uq : uq;
        rem      = neg_a ? -ur : ur;
    end

endmodule

// File: rtl/e_mul_div_unit.sv
// E-stage multiply/divide unit owning HI/LO. Result is computed at
// issue and held pending; a down-counter models the latency.
`timescale 1ns/1ps
module e_mul_div_unit
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    e_mul_div_unit_if.slave   bus
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES
                                                    : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    mdu_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_ok_q, pend_ok_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        op_mul;
    logic        op_div;
    logic        op_mthi;
    logic        op_mtlo;
    logic        mul_signed;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_zero;

    mdu_div_core u_div (
        .dividend  (bus.E_data1),
        .divisor   (bus.E_data2),
        .is_signed (bus.E_mdu_op == MDU_DIV),
        .quot      (quot),
        .rem       (rem),
        .div_zero  (div_zero)
    );

    // low 64 bits of a 64x64 product of extended operands
    always_comb begin
        mul_signed = (bus.E_mdu_op == MDU_MULT);
        mul_a = {{32{mul_signed & bus.E_data1[31]}}, bus.E_data1};
        mul_b = {{32{mul_signed & bus.E_data2[31]}}, bus.E_data2};
        prod  = mul_a * mul_b;
    end

    always_comb begin
        op_mul  = bus.E_start & is_md_op(bus.E_mdu_op) &
                  ((bus.E_mdu_op == MDU_MULT) ||
                   (bus.E_mdu_op == MDU_MULTU));
        op_div  = bus.E_start & is_md_op(bus.E_mdu_op) & ~op_mul;
        op_mthi = bus.E_start & (bus.E_mdu_op == MDU_MTHI);
        op_mtlo = bus.E_start & (bus.E_mdu_op == MDU_MTLO);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_ok_d = pend_ok_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        unique case (state_q)
            S_IDLE: begin
                unique case (1'b1)
                    op_mul: begin
                        pend_hi_d = prod[63:32];
                        pend_lo_d = prod[31:0];
                        pend_ok_d = 1'b1;
                        cnt_d     = CW'(MUL_CYCLES);
                        state_d   = S_RUN;
                    end
                    op_div: begin
                        pend_hi_d = rem;
                        pend_lo_d = quot;
                        pend_ok_d = ~div_zero;
                        cnt_d     = CW'(DIV_CYCLES);
                        state_d   = S_RUN;
                    end
                    op_mthi: hi_d = bus.E_data1;
                    op_mtlo: lo_d = bus.E_data1;
                    default: ;
                endcase
            end
            S_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    if (pend_ok_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_ok_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_ok_q <= pend_ok_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.E_busy    = (cnt_q != '0);
    assign bus.E_hi      = hi_q;
    assign bus.E_lo      = lo_q;
    assign bus.E_mdu_out = (bus.E_mdu_op == MDU_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_e_mul_div_unit.sv
// Scoreboard bench for e_mul_div_unit: driver queues expected HI/LO,
// monitor checks on busy fall or on an explicit read strobe.
`timescale 1ns/1ps
module tb_e_mul_div_unit;
    import mdu_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] out;
        int          busy_n;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic chk = 1'b0;
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   bcnt = 0;
    logic prev_busy = 1'b0;
    exp_t e;

    always #5 clk = ~clk;

    e_mul_div_unit_if bus ();

    e_mul_div_unit #(
        .MUL_CYCLES (5),
        .DIV_CYCLES (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (bus.E_busy) bcnt++;
        if ((prev_busy && !bus.E_busy) || chk) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got hi=%h lo=%h expected none",
                         bus.E_hi, bus.E_lo);
            end else begin
                e = sb.pop_front();
                cmp({e.name, ".hi"}, bus.E_hi, e.hi);
                cmp({e.name, ".lo"}, bus.E_lo, e.lo);
                cmp({e.name, ".out"}, bus.E_mdu_out, e.out);
                if (e.busy_n >= 0)
                    cmp({e.name, ".busy_cycles"}, 32'(bcnt), 32'(e.busy_n));
                else
                    cmp({e.name, ".busy"}, {31'b0, bus.E_busy}, 32'd0);
            end
            bcnt = 0;
        end
        prev_busy = bus.E_busy;
    end

    task automatic start_op(mdu_op_e op, logic [31:0] a, logic [31:0] b);
        bus.E_start  = 1'b1;
        bus.E_mdu_op = op;
        bus.E_data1  = a;
        bus.E_data2  = b;
        @(posedge clk);
        #1;
        bus.E_start  = 1'b0;
        bus.E_mdu_op = MDU_MFLO;
    endtask

    task automatic expect_op(string nm, logic [31:0] hi, logic [31:0] lo,
                             int n);
        exp_t x;
        x = '{nm, hi, lo, lo, n};
        sb.push_back(x);
    endtask

    task automatic wait_idle(string nm);
        int k = 0;
        while (bus.E_busy && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (bus.E_busy) begin
            tests++;
            fails++;
            $display("FAIL %s.timeout: got busy=1 expected busy=0", nm);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic probe(string nm, mdu_op_e op, logic [31:0] hi,
                         logic [31:0] lo);
        exp_t x;
        x = '{nm, hi, lo, (op == MDU_MFHI) ? hi : lo, -1};
        sb.push_back(x);
        bus.E_mdu_op = op;
        chk = 1'b1;
        @(posedge clk);
        #1;
        chk = 1'b0;
        bus.E_mdu_op = MDU_MFLO;
    endtask

    initial begin
        bus.E_start  = 1'b0;
        bus.E_mdu_op = MDU_MFLO;
        bus.E_data1  = '0;
        bus.E_data2  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        probe("reset_state", MDU_MFHI, 32'h0, 32'h0);

        expect_op("reset_mid_run", 32'h0, 32'h0, 1);
        start_op(MDU_MULT, 32'd3, 32'd4);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        probe("no_late_update", MDU_MFLO, 32'h0, 32'h0);

        expect_op("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
        start_op(MDU_MULT, 32'hFFFF_FFFF, 32'd2);
        wait_idle("mult_neg");
        expect_op("multu", 32'h0000_0001, 32'hFFFF_FFFE, 5);
        start_op(MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_idle("multu");

        expect_op("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        start_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle("div_neg");
        expect_op("divu", 32'd1, 32'd3, 10);
        start_op(MDU_DIVU, 32'd7, 32'd2);
        wait_idle("divu");
        expect_op("div_negdivisor", 32'd1, 32'hFFFF_FFFD, 10);
        start_op(MDU_DIV, 32'd7, 32'hFFFF_FFFE);
        wait_idle("div_negdivisor");

        start_op(MDU_MTHI, 32'h1234_5678, 32'h0);
        start_op(MDU_MTLO, 32'h1234_5678, 32'h0);
        expect_op("div_zero", 32'h1234_5678, 32'h1234_5678, 10);
        start_op(MDU_DIV, 32'd5, 32'd0);
        wait_idle("div_zero");
        expect_op("div_ovf", 32'h0, 32'h8000_0000, 10);
        start_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("div_ovf");

        start_op(MDU_MTHI, 32'hAAAA_5555, 32'h0);
        start_op(MDU_MTLO, 32'h0F0F_0F0F, 32'h0);
        probe("mfhi", MDU_MFHI, 32'hAAAA_5555, 32'h0F0F_0F0F);
        probe("mflo", MDU_MFLO, 32'hAAAA_5555, 32'h0F0F_0F0F);

        expect_op("mult_ignore", 32'h0, 32'd6, 5);
        bus.E_start  = 1'b1;
        bus.E_mdu_op = MDU_MULT;
        bus.E_data1  = 32'd2;
        bus.E_data2  = 32'd3;
        @(posedge clk);
        #1;
        bus.E_data1  = 32'd9;
        bus.E_data2  = 32'd9;
        @(posedge clk);
        #1;
        bus.E_start  = 1'b0;
        bus.E_mdu_op = MDU_MFLO;
        wait_idle("mult_ignore");

        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0",
                     sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
